// File: rtl/pal_pkg.sv
// pal_pkg: shared FSM states, default chain sizing and CRC-8 step for the PAL configuration loader.
package pal_pkg;

   typedef enum logic [2:0] {IDLE, FETCH, SHIFT, CRC, DONE, ERR} state_t;

   localparam int PAL_N = 8;
   localparam int PAL_M = 5;
   localparam int PAL_P = 11;

   function automatic int pal_cfg_bits(input int n, input int m, input int p);
      return 2 * n * p + p * m;
   endfunction

   localparam int PAL_CFG_BITS = pal_cfg_bits(PAL_N, PAL_M, PAL_P);

   // MSB-first CRC-8 over one byte, no reflection
   function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data,
                                            input logic [7:0] poly);
      logic [7:0] c;
      c = crc ^ data;
      for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ poly) : (c << 1);
      return c;
   endfunction

endpackage

// File: rtl/pal_crc8.sv
// pal_crc8: byte-wide CRC-8 register with synchronous clear (priority) and update enable.
module pal_crc8 import pal_pkg::*; #(
   parameter logic [7:0] POLY = 8'h07
) (
   input  logic       clk,
   input  logic       res_n,
   input  logic       clr,
   input  logic       en,
   input  logic [7:0] data,
   output logic [7:0] crc
);

   logic [7:0] crc_q, crc_d;

   always_comb crc_d = clr ? 8'h00 : en ? crc8_next(crc_q, data, POLY) : crc_q;

   always_ff @(posedge clk or negedge res_n)
      if (!res_n) crc_q <= 8'h00;
      else        crc_q <= crc_d;

   assign crc = crc_q;

endmodule

// File: rtl/pal_cfg_loader.sv
// pal_cfg_loader: streams a CRC-protected byte image MSB-first into a PAL configuration chain.
module pal_cfg_loader import pal_pkg::*; #(
   parameter int         CFG_BITS = PAL_CFG_BITS,
   parameter logic [7:0] CRC_POLY = 8'h07
) (
   input  logic       clk,
   input  logic       res_n,
   input  logic       start,
   input  logic [7:0] byte_data,
   input  logic       byte_valid,
   output logic       byte_ready,
   output logic       cfg_bit,
   output logic       cfg_en,
   output logic       busy,
   output logic       cfg_ok,
   output logic       cfg_err
);

   localparam int            CW   = $clog2(CFG_BITS + 1);
   localparam logic [CW-1:0] LAST = CW'(CFG_BITS);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
   logic [2:0]    bp_q, bp_d;
   logic [7:0]    byte_q, byte_d, crc;
   logic          ok_q, ok_d, err_q, err_d;
   logic          xfer, load, byte_end, crc_match, crc_xfer;

   assign xfer      = byte_valid & byte_ready;
   assign load      = (state_q == FETCH) & xfer & ~start;
   assign crc_xfer  = (state_q == CRC) & xfer;
   assign cnt_inc   = cnt_q + 1'b1;
   // a byte ends after 8 bits, or early when the chain is full (truncated last byte)
   assign byte_end  = (bp_q == 3'd7) | (cnt_inc == LAST);
   assign crc_match = byte_data == crc;

   pal_crc8 #(.POLY(CRC_POLY)) u_crc (
      .clk  (clk),
      .res_n(res_n),
      .clr  (start),
      .en   (load),
      .data (byte_data),
      .crc  (crc)
   );

   always_ff @(posedge clk or negedge res_n)
      if (!res_n) state_q <= IDLE;
      else        state_q <= state_d;

   always_comb
      state_d = start                            ? FETCH
              : (state_q == FETCH && xfer)       ? SHIFT
              : (state_q == SHIFT && byte_end)   ? ((cnt_inc < LAST) ? FETCH : CRC)
              : (state_q == CRC && xfer)         ? (crc_match ? DONE : ERR)
              : state_q;

   always_comb begin
      cnt_d  = start ? '0 : (state_q == SHIFT) ? cnt_inc : cnt_q;
      bp_d   = (start | load) ? 3'd0 : (state_q == SHIFT) ? bp_q + 3'd1 : bp_q;
      byte_d = load ? byte_data : (state_q == SHIFT) ? {byte_q[6:0], 1'b0} : byte_q;
      ok_d   = ~start & (ok_q | (crc_xfer & crc_match));
      err_d  = ~start & (err_q | (crc_xfer & ~crc_match));
   end

   always_ff @(posedge clk or negedge res_n)
      if (!res_n) begin
         cnt_q  <= '0;
         bp_q   <= 3'd0;
         byte_q <= 8'h00;
         ok_q   <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         bp_q   <= bp_d;
         byte_q <= byte_d;
         ok_q   <= ok_d;
         err_q  <= err_d;
      end

   always_comb begin
      byte_ready = (state_q == FETCH) | (state_q == CRC);
      cfg_en     = state_q == SHIFT;
      cfg_bit    = cfg_en & byte_q[7];
      busy       = byte_ready | cfg_en;
      cfg_ok     = ok_q;
      cfg_err    = err_q;
   end

endmodule

// File: tb/tb_pal_cfg_loader.sv
// tb_pal_cfg_loader: three loaders (231, 8 and 1 chain bits) checked every cycle against a byte-queue model.
module tb_pal_cfg_loader;

   logic       clk = 1'b0;
   logic       res_n = 1'b1;
   logic [2:0] st = '0, bv = '0;
   logic [2:0] rdy, cbit, cen, bsy, ok, err;
   logic [7:0] bd [3];

   int errors = 0;
   int checks = 0;

   bit         mload [3];
   logic [7:0] mq [3];
   int         mlen [3];
   int         mpushed [3];
   logic [7:0] mcrc [3];
   bit         mok [3];
   bit         merr [3];
   int         den [3];

   always #5 clk = ~clk;

   pal_cfg_loader u0 (.clk(clk), .res_n(res_n), .start(st[0]), .byte_data(bd[0]), .byte_valid(bv[0]),
      .byte_ready(rdy[0]), .cfg_bit(cbit[0]), .cfg_en(cen[0]), .busy(bsy[0]), .cfg_ok(ok[0]), .cfg_err(err[0]));
   pal_cfg_loader #(.CFG_BITS(8)) u1 (.clk(clk), .res_n(res_n), .start(st[1]), .byte_data(bd[1]),
      .byte_valid(bv[1]), .byte_ready(rdy[1]), .cfg_bit(cbit[1]), .cfg_en(cen[1]), .busy(bsy[1]),
      .cfg_ok(ok[1]), .cfg_err(err[1]));
   pal_cfg_loader #(.CFG_BITS(1)) u2 (.clk(clk), .res_n(res_n), .start(st[2]), .byte_data(bd[2]),
      .byte_valid(bv[2]), .byte_ready(rdy[2]), .cfg_bit(cbit[2]), .cfg_en(cen[2]), .busy(bsy[2]),
      .cfg_ok(ok[2]), .cfg_err(err[2]));

   function automatic int cb(input int k);
      return (k == 0) ? 231 : (k == 1) ? 8 : 1;
   endfunction

   // bit-serial reference CRC, one feedback step per data bit
   function automatic logic [7:0] crc_bitwise(input logic [7:0] c, input logic [7:0] d);
      for (int i = 7; i >= 0; i--) c = {c[6:0], 1'b0} ^ ((c[7] ^ d[i]) ? 8'h07 : 8'h00);
      return c;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   always @(negedge clk)
      for (int k = 0; k < 3; k++) begin
         if (!res_n) begin
            mload[k] = 0; mlen[k] = 0; mpushed[k] = 0; mcrc[k] = 0; mok[k] = 0; merr[k] = 0; den[k] = 0;
         end
         chk($sformatf("u%0d busy", k), bsy[k], mload[k]);
         chk($sformatf("u%0d byte_ready", k), rdy[k], mload[k] && mlen[k] == 0);
         chk($sformatf("u%0d cfg_en", k), cen[k], mlen[k] != 0);
         chk($sformatf("u%0d cfg_bit", k), cbit[k], (mlen[k] != 0) ? mq[k][7] : 1'b0);
         chk($sformatf("u%0d cfg_ok", k), ok[k], mok[k]);
         chk($sformatf("u%0d cfg_err", k), err[k], merr[k]);
         den[k] += int'(cen[k]);
         if (res_n) begin
            if (st[k]) begin
               mload[k] = 1; mlen[k] = 0; mpushed[k] = 0; mcrc[k] = 0; mok[k] = 0; merr[k] = 0; den[k] = 0;
            end else if (mlen[k] != 0) begin
               mq[k] = mq[k] << 1;
               mlen[k]--;
            end else if (mload[k] && bv[k]) begin
               if (mpushed[k] < cb(k)) begin
                  mq[k] = bd[k];
                  mlen[k] = (cb(k) - mpushed[k] >= 8) ? 8 : cb(k) - mpushed[k];
                  mpushed[k] += mlen[k];
                  mcrc[k] = crc_bitwise(mcrc[k], bd[k]);
               end else begin
                  mload[k] = 0;
                  mok[k] = bd[k] == mcrc[k];
                  merr[k] = !mok[k];
                  chk($sformatf("u%0d cfg_en count", k), den[k], cb(k));
               end
            end
         end
      end

   task automatic pulse(input int k);
      st[k] = 1'b1;
      @(posedge clk); #1;
      st[k] = 1'b0;
   endtask

   task automatic send(input int k, input logic [7:0] d, input bit thr);
      int n = 0;
      bit done = 0;
      bd[k] = d;
      while (!done && n < 200) begin
         bv[k] = !thr || (n % 3 == 0);
         @(negedge clk);
         done = bv[k] && rdy[k];
         @(posedge clk); #1;
         n++;
      end
      bv[k] = 1'b0;
      if (!done) chk($sformatf("u%0d send timeout", k), 1, 0);
   endtask

   task automatic load(input int k, input logic [7:0] d, input logic [7:0] x, input bit thr, input bit do_st);
      logic [7:0] c = 8'h00;
      if (do_st) pulse(k);
      for (int i = 0; i < (cb(k) + 7) / 8; i++) begin
         send(k, d, thr);
         c = crc_bitwise(c, d);
      end
      send(k, c ^ x, thr);
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < 3; k++) bd[k] = 8'h00;
      #1 res_n = 1'b0;
      repeat (3) @(posedge clk);
      #3 res_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++)
         chk($sformatf("u%0d reset outputs", k), {rdy[k], cbit[k], cen[k], bsy[k], ok[k], err[k]}, 0);

      load(0, 8'hA5, 8'h00, 0, 1);
      chk("nominal ok/err/busy", {ok[0], err[0], bsy[0]}, 3'b100);
      chk("nominal en count", den[0], 231);

      load(0, 8'hA5, 8'h01, 0, 1);
      chk("bad crc ok/err", {ok[0], err[0]}, 2'b01);
      chk("bad crc en count", den[0], 231);

      load(0, 8'hA5, 8'h00, 1, 1);
      chk("throttled ok", {ok[0], err[0]}, 2'b10);

      pulse(0);
      for (int i = 0; i < 10; i++) send(0, 8'hA5, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("abort precond shifting", cen[0], 1);
      pulse(0);
      @(negedge clk);
      chk("abort en/ready/busy/flags", {cen[0], rdy[0], bsy[0], ok[0], err[0]}, 5'b01100);
      @(posedge clk); #1;
      load(0, 8'hA5, 8'h00, 0, 0);
      chk("after abort ok", {ok[0], err[0]}, 2'b10);

      pulse(0);
      for (int i = 0; i < 3; i++) send(0, 8'h5A, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("reset precond shifting", cen[0], 1);
      #2 res_n = 1'b0;
      #1 chk("async reset outputs", {rdy[0], cbit[0], cen[0], bsy[0], ok[0], err[0]}, 0);
      repeat (2) @(posedge clk);
      #2 res_n = 1'b1;
      repeat (5) @(posedge clk);
      #1 chk("idle after reset", {rdy[0], cen[0], bsy[0]}, 0);

      pulse(1);
      send(1, 8'h01, 0);
      send(1, 8'h07, 0);
      repeat (10) @(posedge clk);
      #1;
      chk("cb8 literal crc ok", {ok[1], err[1]}, 2'b10);
      chk("cb8 en count", den[1], 8);
      pulse(1);
      send(1, 8'h01, 0);
      send(1, 8'h06, 0);
      repeat (10) @(posedge clk);
      #1 chk("cb8 literal bad crc", {ok[1], err[1]}, 2'b01);

      pulse(1);
      bd[1] = 8'hFF;
      bv[1] = 1'b1;
      st[1] = 1'b1;
      @(posedge clk); #1;
      st[1] = 1'b0;
      bv[1] = 1'b0;
      chk("start beats transfer", {rdy[1], cen[1]}, 2'b10);
      load(1, 8'h5A, 8'h00, 0, 0);
      chk("cb8 model load ok", ok[1], 1);

      pulse(2);
      send(2, 8'h80, 0);
      chk("cb1 single bit", {cen[2], cbit[2]}, 2'b11);
      send(2, 8'h89, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("cb1 literal crc ok", {ok[2], err[2]}, 2'b10);
      chk("cb1 en count", den[2], 1);
      pulse(2);
      send(2, 8'h7F, 0);
      chk("cb1 bit7 only", {cen[2], cbit[2]}, 2'b10);
      send(2, 8'h88, 0);
      repeat (3) @(posedge clk);
      #1 chk("cb1 bad crc", {ok[2], err[2]}, 2'b01);
      load(2, 8'h7F, 8'h00, 1, 1);
      chk("cb1 model load ok", ok[2], 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pal_cfg_loader.md
PAL_CFG_LOADER -- requirements
Module: pal_cfg_loader

Interface
REQ-001 Parameter CFG_BITS, default 231, total PAL configuration chain length in bits (AND plane 2*8*11 plus OR plane 11*5); SHALL be at least 1.
REQ-002 Parameter CRC_POLY, default 8'h07, CRC-8 generator polynomial with init 8'h00, no reflection, no final XOR.
REQ-003 clk  in  1  single clock; every flop SHALL be clocked on its rising edge.
REQ-004 res_n  in  1  reset, asynchronous and active-low.
REQ-005 start  in  1  single-cycle request to begin a new load; honoured in every state.
REQ-006 byte_data  in  8  configuration or CRC byte.
REQ-007 byte_valid  in  1  byte_data is valid.
REQ-008 byte_ready  out  1  loader accepts a byte; a transfer occurs when byte_valid and byte_ready are both high.
REQ-009 cfg_bit  out  1  serial bit to the PAL cfg input.
REQ-010 cfg_en  out  1  qualifier for the PAL en input; the PAL samples cfg_bit on every clk edge where cfg_en is high.
REQ-011 busy  out  1  high in every state except IDLE, DONE and ERR.
REQ-012 cfg_ok  out  1  load complete and CRC matched.
REQ-013 cfg_err  out  1  load complete and CRC mismatched.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, FETCH, SHIFT, CRC, DONE and ERR.
REQ-015 IDLE to FETCH on start; bit counter cleared; CRC register cleared; cfg_ok and cfg_err cleared.
REQ-016 FETCH: byte_ready=1; on transfer, latch the byte, update CRC over the full 8 bits, go to SHIFT.
REQ-017 SHIFT: byte_ready=0; cfg_en=1; one bit per cycle, MSB first.
- Full byte: 8 bits.
- Final byte when CFG_BITS mod 8 = R is nonzero: only bits [7:8-R] are shifted; bits [7-R:0] are still included in the CRC.
REQ-018 After a byte is exhausted, go to FETCH if the bit counter is below CFG_BITS, otherwise go to CRC.
REQ-019 CRC: byte_ready=1; on transfer, compare against the CRC register. Equal goes to DONE, with cfg_ok=1. Unequal goes to ERR, with cfg_err=1.
REQ-020 DONE and ERR hold their flag until start, then behave as in IDLE on start.
REQ-021 cfg_en SHALL be 0 outside SHIFT, and cfg_bit SHALL be 0 whenever cfg_en is 0.
REQ-022 The total count of cycles with cfg_en=1 per load SHALL equal exactly CFG_BITS.
REQ-023 Byte-to-first-bit latency: the first cfg_en cycle is the cycle immediately after the FETCH transfer.
REQ-024 Bubbles on byte_valid in FETCH or CRC SHALL stall without shifting; the upstream may hold byte_data arbitrarily long.
REQ-025 start in FETCH, SHIFT or CRC SHALL abort the load and restart in FETCH next cycle; counter, CRC and flags are cleared, and no further bit of the aborted byte is shifted.
REQ-026 start in the same cycle as a FETCH or CRC transfer: start wins and the byte is discarded.
REQ-027 The bit counter SHALL be $clog2(CFG_BITS+1) bits wide and SHALL never wrap within a load.

Reset
REQ-028 res_n low SHALL asynchronously force IDLE.
REQ-029 Reset values: byte_ready=0, cfg_bit=0, cfg_en=0, busy=0, cfg_ok=0, cfg_err=0; counter, CRC register and byte register all zero.
REQ-030 Reset mid-load SHALL drop cfg_en within the reset assertion, without a partial extra shift.
REQ-031 After release, the loader SHALL stay idle until start.

Structure
REQ-032 The shared package pal_pkg SHALL hold:
- the FSM state enum;
- the default CFG_BITS derivation from PAL N, M and P (2*N*P + P*M);
- the CRC-8 next-state function.
REQ-033 One sub-module, pal_crc8, SHALL provide the byte-wide CRC update (combinational next value plus registered state with clear and enable); everything else stays in pal_cfg_loader.

Verification
REQ-034 Nominal load:
- Stimulus: CFG_BITS=231, 29 bytes of 8'hA5 back-to-back, then the correct CRC byte.
- Response: exactly 231 cfg_en cycles with serial pattern 1010_0101 repeating, the last byte truncated to 1010_010; cfg_ok=1, busy=0.
REQ-035 Bad CRC:
- Stimulus: same payload, CRC byte XOR 8'h01.
- Response: cfg_err=1, cfg_ok=0; 231 bits still shifted.
REQ-036 Throttled source:
- Stimulus: byte_valid asserted one cycle in three.
- Response: same cfg_bit sequence as REQ-034; no cfg_en during stalls.
REQ-037 Abort:
- Stimulus: start pulse during SHIFT of byte 10.
- Response: cfg_en low the next cycle; FETCH; flags clear; a fresh full load then completes with cfg_ok=1.
REQ-038 Async reset:
- Stimulus: res_n low mid-SHIFT, asynchronous to clk.
- Response: all outputs zero immediately; after release, no activity until start.
REQ-039 Boundary:
- Stimulus: CFG_BITS=8 (one full byte) and CFG_BITS=1.
- Response: exactly 8 and 1 cfg_en cycles respectively, the latter shifting bit 7 only; CRC still checked.
